// File: rtl/serial_sub_ctrl_if.sv
// serial_sub_ctrl_if: host-side start/operand/result bundle for the serial subtractor
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borrow_out;
  modport master(output start, a, b, input busy, done, diff, borrow_out);
  modport slave(input start, a, b, output busy, done, diff, borrow_out);
endinterface

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: LSB-first bit-serial unsigned subtractor with start/done handshake
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module serial_sub_ctrl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_sub_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] sa, sb, diff;
  logic [CW-1:0] cnt;
  logic bflop, borrow, d1, b1, d, b2, bo, last;
  half_subtractor hs0 (.x(sa[0]), .y(sb[0]), .d(d1), .bo(b1));
  half_subtractor hs1 (.x(d1), .y(bflop), .d(d), .bo(b2));
  assign bo = b1 | b2;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb
    next = state == IDLE ? (bus.start ? RUN : IDLE) :
           state == RUN  ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    bus.busy       = state == RUN;
    bus.done       = state == DONE;
    bus.diff       = diff;
    bus.borrow_out = borrow;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      diff   <= '0;
      cnt    <= '0;
      bflop  <= 1'b0;
      borrow <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sa    <= bus.a;
      sb    <= bus.b;
      diff  <= '0;
      cnt   <= '0;
      bflop <= 1'b0;
    end else if (state == RUN) begin
      diff  <= {d, diff[WIDTH-1:1]};
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      bflop <= bo;
      cnt   <= cnt + CW'(1);
      if (last) borrow <= bo;
    end
  end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench for 8- and 16-bit serial subtractor instances
module tb_serial_sub_ctrl;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int passed = 0;
  logic [16:0] q[$];
  serial_sub_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_sub_ctrl_if #(.WIDTH(16)) bus16 ();
  serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [16:0] model(input int w, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ma, mb, m;
    m  = w == 8 ? 16'h00FF : 16'hFFFF;
    ma = a & m;
    mb = b & m;
    return {ma < mb, (ma - mb) & m};
  endfunction

  task automatic run(input int w, input logic [15:0] a, input logic [15:0] b, input bit timing, input string name);
    logic [16:0] exp, got;
    int busy_n, lat;
    bit seen;
    busy_n = 0;
    lat = 0;
    seen = 0;
    q.push_back(model(w, a, b));
    @(negedge clk);
    if (w == 8) begin bus8.start = 1; bus8.a = a[7:0]; bus8.b = b[7:0]; end
    else begin bus16.start = 1; bus16.a = a; bus16.b = b; end
    @(negedge clk);
    bus8.start = 0; bus16.start = 0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    for (int i = 0; i < 3 * w; i++) begin
      if (w == 8 ? bus8.done : bus16.done) begin seen = 1; lat = i; break; end
      busy_n += int'(w == 8 ? bus8.busy : bus16.busy);
      @(negedge clk);
    end
    exp = q.pop_front();
    total++;
    if (!seen) begin
      $display("FAIL %s timeout: no done within %0d cycles", name, 3 * w);
      return;
    end
    passed++;
    got = w == 8 ? {bus8.borrow_out, 8'h00, bus8.diff} : {bus16.borrow_out, bus16.diff};
    chk({name, " result"}, got, exp);
    if (timing) begin
      chk({name, " busy_cycles"}, 17'(busy_n), 17'(w));
      chk({name, " done_latency"}, 17'(lat), 17'(w));
      @(negedge clk);
      chk({name, " done_pulse"}, {16'h0, w == 8 ? bus8.done : bus16.done}, 17'h0);
      got = w == 8 ? {bus8.borrow_out, 8'h00, bus8.diff} : {bus16.borrow_out, bus16.diff};
      chk({name, " held"}, got, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset8", {bus8.busy, bus8.done, bus8.borrow_out, 6'h0, bus8.diff}, 17'h0);
    chk("reset16", {bus16.busy, bus16.done, bus16.borrow_out, bus16.diff[13:0]}, 17'h0);
    chk("reset16_hi", {15'h0, bus16.diff[15:14]}, 17'h0);
    repeat (3) @(negedge clk);
    chk("idle8", {bus8.busy, bus8.done, bus8.borrow_out, 6'h0, bus8.diff}, 17'h0);
  endtask

  task automatic test_basic;
    run(8, 16'd200, 16'd55, 1, "basic_200_55");
    chk("basic_value", {bus8.borrow_out, 8'h0, bus8.diff}, {1'b0, 8'h0, 8'd145});
  endtask

  task automatic test_edges;
    run(8, 16'd5, 16'd9, 1, "edge_5_9");
    chk("edge_5_9_value", {bus8.borrow_out, 8'h0, bus8.diff}, {1'b1, 8'h0, 8'hFC});
    run(8, 16'hFF, 16'hFF, 0, "edge_ff_ff");
    run(8, 16'd0, 16'd1, 0, "edge_0_1");
    run(16, 16'd0, 16'hFFFF, 1, "edge16_0_ffff");
  endtask

  task automatic test_back_to_back;
    int ndone, first, prev;
    logic [16:0] exp;
    ndone = 0;
    first = -1;
    prev = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL b2b spurious done at %0d", k);
        end else begin
          exp = q.pop_front();
          chk("b2b result", {bus8.borrow_out, 8'h0, bus8.diff}, exp);
          if (prev >= 0) chk("b2b spacing", 17'(k - prev), 17'd10);
          else first = k;
          prev = k;
          ndone++;
        end
      end
      bus8.start = k < 30;
      bus8.a = 8'($urandom);
      bus8.b = 8'($urandom);
      if (k < 30 && k % 10 == 0) q.push_back(model(8, {8'h0, bus8.a}, {8'h0, bus8.b}));
    end
    bus8.start = 0;
    chk("b2b done_count", 17'(ndone), 17'd3);
    chk("b2b first_done", 17'(first), 17'd9);
    q.delete();
  endtask

  task automatic test_reset_mid;
    int spur;
    spur = 0;
    @(negedge clk);
    bus8.start = 1; bus8.a = 8'hAA; bus8.b = 8'h55;
    @(negedge clk);
    bus8.start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst outputs", {bus8.busy, bus8.done, bus8.borrow_out, 6'h0, bus8.diff}, 17'h0);
    repeat (12) begin
      @(negedge clk);
      spur += int'(bus8.done);
    end
    chk("midrst no_done", 17'(spur), 17'h0);
    run(8, 16'd3, 16'd1, 0, "after_rst_3_1");
    chk("after_rst_value", {bus8.borrow_out, 8'h0, bus8.diff}, 17'd2);
  endtask

  task automatic test_random;
    for (int i = 0; i < 500; i++) begin
      run(8, 16'($urandom), 16'($urandom), 0, "rand8");
      run(16, 16'($urandom), 16'($urandom), 0, "rand16");
    end
  endtask

  initial begin
    bus8.start = 0; bus8.a = 0; bus8.b = 0;
    bus16.start = 0; bus16.a = 0; bus16.b = 0;
    test_reset;
    test_basic;
    test_edges;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
